vred_logic_pipe: RTL and testbench
==================================

Name: vred_logic_pipe

Overview:
- Parametrised, pipelined vector AND/OR/XOR reduction unit (vredand/vredor/vredxor) in the vALU.
- Accepts one DATA_WIDTH-bit beat of vs2 elements per cycle, with a per-element mask.
- Folds each beat to one SEW-wide element and accumulates across beats, from in_start to in_end, starting from the scalar seed in vs1[0].
- Emits one result word, with byte enables and writeback address, per reduction.

Parameters:
- DATA_WIDTH, 128, datapath width; power of two, >=64.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width; also mask width.
- ADDR_WIDTH, 32, writeback address width.
- OPSEL_WIDTH, 2, op select width.
- SEW_WIDTH, 2, element width code (0=8b, 1=16b, 2=32b, 3=64b).
- ENABLE_64_BIT, 1, 0 makes SEW=3 illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vec0  in  DATA_WIDTH  vs2 elements of this beat
- in_vec1  in  DATA_WIDTH  seed; element 0 (low SEW bits) sampled on start beat only
- in_mask  in  BE_WIDTH  bit i = element i active; bits >= DATA_WIDTH/EW ignored
- in_valid  in  1  beat valid
- in_start  in  1  first beat of reduction
- in_end  in  1  last beat of reduction
- in_opSel  in  OPSEL_WIDTH  01=AND, 10=OR, 11=XOR, 00=illegal
- in_sew  in  SEW_WIDTH  element width code
- in_addr  in  ADDR_WIDTH  writeback address
- out_addr  out  ADDR_WIDTH  address of end beat
- out_vec  out  DATA_WIDTH  result, zero-extended above EW
- out_valid  out  1  one-cycle result strobe
- out_be  out  BE_WIDTH  result byte enables
- out_err  out  1  one-cycle pulse: illegal beat dropped

Behaviour:
- Reset: every output, all pipeline valid/start/end flags and the accumulator clear to 0. A reduction in flight is discarded; no out_valid is issued for it.
- EW = 8<<in_sew. Element i = in_vec0[i*EW +: EW].
- Illegal beat: in_valid with opSel=00, or SEW=3 with ENABLE_64_BIT=0.
  - Dropped at input, treated as in_valid=0.
  - out_err=1 on the next cycle.
- Stage S0 (register): masked-off elements replaced by identity (AND: all ones; OR/XOR: zero). opSel, sew, start, end, addr and seed are captured with the beat.
- Fold stages F1..FK, K=log2(DATA_WIDTH/8), each registered:
  - Stage j takes width W, outputs W/2 = low half op high half, when W/2 >= EW.
  - Otherwise the low W/2 bits pass unchanged.
  - After FK, the low EW bits hold the beat result.
- Accumulate stage A (register), valid beats only:
  - start: acc = beat op seed.
  - otherwise: acc = beat op acc.
  - Bubbles hold acc.
  - start&end together is a single-beat reduction.
  - An end without prior start accumulates onto the held acc.
- Output register:
  - On the cycle after A processes an end beat: out_valid=1, out_vec=acc zero-extended, out_addr = end-beat addr, out_be = (1<<(1<<sew))-1, i.e. 0x1/0x3/0xF/0xFF.
  - Otherwise out_vec, out_be and out_valid are 0; out_addr holds.
- Latency: end beat at cycle t gives out_valid at t+K+3 (DATA_WIDTH=128 gives 7; DATA_WIDTH=64 gives 6).
- Throughput: one beat per cycle, no backpressure. Bubbles anywhere between start and end are allowed.
- Back-to-back: end at t, start at t+1 yields two independent correct results at consecutive cycles. The new start reseeds and never sees the old acc.
- opSel and sew are sampled per beat; they must stay constant within a reduction, but are not checked.

Test Plan:
- DW=128, sew=0, XOR: bytes 0x01..0x10, mask 0xFFFF, seed 0x00, start&end -> out_vec=0x10, out_be=0x0001, out_valid exactly 7 cycles later.
- sew=2, AND: elements {0xFFFF0000, 0x0000FFFF, 0x12345678, 0xFFFFFFFF}, in_mask=0x0009, seed 0xFFFFFFFF -> out_vec=0xFFFF0000, out_be=0x000F.
- sew=3, OR, two beats with a 2-cycle bubble between: beat1 {0x1, 0x2} with start, beat2 {0x4, 0x8} with end, seed 0x10 -> out_vec=0x1F, out_be=0x00FF, addr from beat2.
- Back-to-back: XOR sew=1 single-beat, then next cycle AND sew=1 single-beat, seed 0xFFFF, elements all 0x00FF -> results 0x0000 then 0x00FF on consecutive cycles.
- ENABLE_64_BIT=0, sew=3 beat; also a beat with opSel=00 -> out_err pulse one cycle after each, no out_valid, acc unchanged.
- Start beat (OR, 0xAA elements), rst asserted mid-flight, then start&end beat of zeros with seed 0 -> only one out_valid, out_vec=0x00.

Source files
------------

// File: rtl/vred_logic_pipe.sv
// vred_logic_pipe: pipelined vector AND/OR/XOR reduction (vredand/vredor/vredxor).
//
// Each beat of vs2 elements is masked (inactive elements become the identity
// of the operation) and then folded in halves down to one SEW-wide element.
// Beat results are accumulated from the start beat (seeded from vs1[0]) to
// the end beat, and one result word is emitted per reduction.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_vec0              vs2 elements of this beat
//   in_vec1              seed; low EW bits used on the start beat
//   in_mask              per-element active mask
//   in_valid             beat valid
//   in_start / in_end    first / last beat of a reduction
//   in_opSel             01=AND, 10=OR, 11=XOR (00 illegal)
//   in_sew               element width code, EW = 8 << in_sew
//   in_addr              writeback address
//   out_vec              reduction result, zero-extended above EW
//   out_be               result byte enables
//   out_addr             writeback address of the end beat
//   out_valid            one-cycle result strobe
//   out_err              one-cycle pulse for a dropped illegal beat
//
// Pipeline: S0 -> F1..FK (K = log2(DATA_WIDTH/8)) -> A -> output register.
// An end beat presented in cycle t produces out_valid in cycle t+K+3.
module vred_logic_pipe #(
    parameter int DATA_WIDTH    = 128,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int OPSEL_WIDTH   = 2,
    parameter int SEW_WIDTH     = 2,
    parameter int ENABLE_64_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_vec0,
    input  logic [DATA_WIDTH-1:0]  in_vec1,
    input  logic [BE_WIDTH-1:0]    in_mask,
    input  logic                   in_valid,
    input  logic                   in_start,
    input  logic                   in_end,
    input  logic [OPSEL_WIDTH-1:0] in_opSel,
    input  logic [SEW_WIDTH-1:0]   in_sew,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [DATA_WIDTH-1:0]  out_vec,
    output logic                   out_valid,
    output logic [BE_WIDTH-1:0]    out_be,
    output logic                   out_err
);

    localparam int K  = $clog2(DATA_WIDTH / 8);
    localparam int MW = $clog2(BE_WIDTH);

    function automatic int ew_bits(input logic [SEW_WIDTH-1:0] sew);
        return 8 << sew;
    endfunction

    // All-ones in the low EW bits; the shift wraps to zero for EW == DATA_WIDTH,
    // which the subtraction turns into all ones.
    function automatic logic [DATA_WIDTH-1:0] ew_mask(input logic [SEW_WIDTH-1:0] sew);
        return (DATA_WIDTH'(1) << ew_bits(sew)) - DATA_WIDTH'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] apply_op(input logic [DATA_WIDTH-1:0]  a,
                                                       input logic [DATA_WIDTH-1:0]  b,
                                                       input logic [OPSEL_WIDTH-1:0] op);
        case (op)
            OPSEL_WIDTH'(1): return a & b;
            OPSEL_WIDTH'(2): return a | b;
            OPSEL_WIDTH'(3): return a ^ b;
            default:         return a;
        endcase
    endfunction

    // Replace inactive elements by the identity: ones for AND, zeros for OR/XOR.
    function automatic logic [DATA_WIDTH-1:0] identity_fill(input logic [DATA_WIDTH-1:0]  vec,
                                                            input logic [BE_WIDTH-1:0]    mask,
                                                            input logic [OPSEL_WIDTH-1:0] op,
                                                            input logic [SEW_WIDTH-1:0]   sew);
        logic [DATA_WIDTH-1:0] r;
        logic [MW-1:0]         e;
        logic                  id;
        r  = vec;
        id = (op == OPSEL_WIDTH'(1));
        for (int b = 0; b < DATA_WIDTH; b++) begin
            e = MW'(b >> (3 + int'(sew)));
            if (!mask[e]) r[b] = id;
        end
        return r;
    endfunction

    function automatic logic [BE_WIDTH-1:0] result_be(input logic [SEW_WIDTH-1:0] sew);
        return BE_WIDTH'((1 << (1 << sew)) - 1);
    endfunction

    // Index 0 is S0, index j is fold stage Fj.
    logic [DATA_WIDTH-1:0]  vec_p   [0:K];
    logic [DATA_WIDTH-1:0]  seed_p  [0:K];
    logic [OPSEL_WIDTH-1:0] op_p    [0:K];
    logic [SEW_WIDTH-1:0]   sew_p   [0:K];
    logic [ADDR_WIDTH-1:0]  addr_p  [0:K];
    logic                   vld_p   [0:K];
    logic                   start_p [0:K];
    logic                   end_p   [0:K];

    logic                  illegal;
    logic [DATA_WIDTH-1:0] seed_in;
    logic [DATA_WIDTH-1:0] beat;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  done;
    logic [ADDR_WIDTH-1:0] done_addr;
    logic [SEW_WIDTH-1:0]  done_sew;

    // Illegal beats are dropped here and never enter the pipeline.
    assign illegal = in_valid &&
                     ((in_opSel == '0) ||
                      ((ENABLE_64_BIT == 0) && (in_sew == SEW_WIDTH'(3))));
    assign seed_in = in_vec1 & ew_mask(in_sew);

    // ---- S0: mask to identity, capture side-band with the beat ----
    always_ff @(posedge clk) begin
        vec_p[0]  <= identity_fill(in_vec0, in_mask, in_opSel, in_sew);
        seed_p[0] <= seed_in;
        op_p[0]   <= in_opSel;
        sew_p[0]  <= in_sew;
        addr_p[0] <= in_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p[0]   <= 1'b0;
            start_p[0] <= 1'b0;
            end_p[0]   <= 1'b0;
        end else begin
            vld_p[0]   <= in_valid && !illegal;
            start_p[0] <= in_start;
            end_p[0]   <= in_end;
        end
    end

    // ---- F1..FK: fold low half with high half while the half still holds an element ----
    always_ff @(posedge clk) begin
        for (int j = 1; j <= K; j++) begin
            if ((DATA_WIDTH >> j) >= ew_bits(sew_p[j-1]))
                vec_p[j] <= apply_op(vec_p[j-1], vec_p[j-1] >> (DATA_WIDTH >> j), op_p[j-1]);
            else
                vec_p[j] <= vec_p[j-1];
            seed_p[j] <= seed_p[j-1];
            op_p[j]   <= op_p[j-1];
            sew_p[j]  <= sew_p[j-1];
            addr_p[j] <= addr_p[j-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 1; j <= K; j++) begin
            if (rst) begin
                vld_p[j]   <= 1'b0;
                start_p[j] <= 1'b0;
                end_p[j]   <= 1'b0;
            end else begin
                vld_p[j]   <= vld_p[j-1];
                start_p[j] <= start_p[j-1];
                end_p[j]   <= end_p[j-1];
            end
        end
    end

    // ---- A: accumulate beat result onto seed (start) or held accumulator ----
    always_comb begin
        beat     = vec_p[K] & ew_mask(sew_p[K]);
        acc_next = apply_op(beat, start_p[K] ? seed_p[K] : acc, op_p[K]) & ew_mask(sew_p[K]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            done <= 1'b0;
        end else begin
            if (vld_p[K]) acc <= acc_next;
            done <= vld_p[K] && end_p[K];
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p[K] && end_p[K]) begin
            done_addr <= addr_p[K];
            done_sew  <= sew_p[K];
        end
    end

    // ---- Output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_be    <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= done;
            out_vec   <= done ? acc : '0;
            out_be    <= done ? result_be(done_sew) : '0;
            if (done) out_addr <= done_addr;
            out_err   <= illegal;
        end
    end

endmodule

// File: tb/tb_vred_logic_pipe.sv
// Scoreboard bench for vred_logic_pipe: a 128-bit instance (64-bit elements
// enabled) and a 64-bit instance with 64-bit elements disabled.
module tb_vred_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 128-bit instance
    logic [127:0] in_vec0, in_vec1;
    logic [15:0]  in_mask;
    logic         in_valid, in_start, in_end;
    logic [1:0]   in_opSel, in_sew;
    logic [31:0]  in_addr;
    logic [31:0]  out_addr;
    logic [127:0] out_vec;
    logic         out_valid;
    logic [15:0]  out_be;
    logic         out_err;

    // 64-bit instance
    logic [63:0]  b_vec0, b_vec1;
    logic [7:0]   b_mask;
    logic         b_valid, b_start, b_end;
    logic [1:0]   b_opSel, b_sew;
    logic [31:0]  b_addr;
    logic [31:0]  b_out_addr;
    logic [63:0]  b_out_vec;
    logic         b_out_valid;
    logic [7:0]   b_out_be;
    logic         b_out_err;

    vred_logic_pipe #(.DATA_WIDTH(128), .ENABLE_64_BIT(1)) dut (
        .clk(clk), .rst(rst),
        .in_vec0(in_vec0), .in_vec1(in_vec1), .in_mask(in_mask),
        .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
        .in_opSel(in_opSel), .in_sew(in_sew), .in_addr(in_addr),
        .out_addr(out_addr), .out_vec(out_vec), .out_valid(out_valid),
        .out_be(out_be), .out_err(out_err)
    );

    vred_logic_pipe #(.DATA_WIDTH(64), .ENABLE_64_BIT(0)) dut64 (
        .clk(clk), .rst(rst),
        .in_vec0(b_vec0), .in_vec1(b_vec1), .in_mask(b_mask),
        .in_valid(b_valid), .in_start(b_start), .in_end(b_end),
        .in_opSel(b_opSel), .in_sew(b_sew), .in_addr(b_addr),
        .out_addr(b_out_addr), .out_vec(b_out_vec), .out_valid(b_out_valid),
        .out_be(b_out_be), .out_err(b_out_err)
    );

    typedef struct {
        logic [127:0] vec;
        logic [15:0]  be;
        logic [31:0]  addr;
        int           cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   qe_a[$];
    int   qe_b[$];
    exp_t ea, eb;
    int   ee;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_a(input logic [127:0] v, input logic [15:0] be, input logic [31:0] a);
        exp_t t;
        t.vec = v; t.be = be; t.addr = a; t.cyc = cyc + 7;
        q_a.push_back(t);
    endtask

    task automatic expect_b(input logic [127:0] v, input logic [15:0] be, input logic [31:0] a);
        exp_t t;
        t.vec = v; t.be = be; t.addr = a; t.cyc = cyc + 6;
        q_b.push_back(t);
    endtask

    task automatic beat_a(input logic [127:0] v0, input logic [127:0] v1, input logic [15:0] m,
                          input logic s, input logic e, input logic [1:0] op,
                          input logic [1:0] sew, input logic [31:0] a);
        in_vec0 = v0; in_vec1 = v1; in_mask = m; in_start = s; in_end = e;
        in_opSel = op; in_sew = sew; in_addr = a; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
    endtask

    task automatic beat_b(input logic [63:0] v0, input logic [63:0] v1, input logic [7:0] m,
                          input logic s, input logic e, input logic [1:0] op,
                          input logic [1:0] sew, input logic [31:0] a);
        b_vec0 = v0; b_vec1 = v1; b_mask = m; b_start = s; b_end = e;
        b_opSel = op; b_sew = sew; b_addr = a; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0; b_start = 1'b0; b_end = 1'b0;
    endtask

    // Monitor for the 128-bit instance
    always @(negedge clk) begin
        if (out_valid) begin
            if (q_a.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_valid: got out_vec 0x%0h, required no output (cycle %0d)", out_vec, cyc);
            end else begin
                ea = q_a.pop_front();
                chk("a_vec",  out_vec,  ea.vec);
                chk("a_be",   out_be,   ea.be);
                chk("a_addr", out_addr, ea.addr);
                chk("a_latency_cycle", cyc, ea.cyc);
            end
        end
        if (out_err) begin
            if (qe_a.size() == 0) begin
                checks++;
                $display("FAIL a_unexpected_err: got out_err 1, required 0 (cycle %0d)", cyc);
            end else begin
                ee = qe_a.pop_front();
                chk("a_err_cycle", cyc, ee);
            end
        end
    end

    // Monitor for the 64-bit instance
    always @(negedge clk) begin
        if (b_out_valid) begin
            if (q_b.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_valid: got out_vec 0x%0h, required no output (cycle %0d)", b_out_vec, cyc);
            end else begin
                eb = q_b.pop_front();
                chk("b_vec",  b_out_vec,  eb.vec);
                chk("b_be",   b_out_be,   eb.be);
                chk("b_addr", b_out_addr, eb.addr);
                chk("b_latency_cycle", cyc, eb.cyc);
            end
        end
        if (b_out_err) begin
            if (qe_b.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected_err: got out_err 1, required 0 (cycle %0d)", cyc);
            end else begin
                ee = qe_b.pop_front();
                chk("b_err_cycle", cyc, ee);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_vec0 = '0; in_vec1 = '0; in_mask = '0; in_valid = 1'b0; in_start = 1'b0;
        in_end = 1'b0; in_opSel = 2'b01; in_sew = 2'd0; in_addr = '0;
        b_vec0 = '0; b_vec1 = '0; b_mask = '0; b_valid = 1'b0; b_start = 1'b0;
        b_end = 1'b0; b_opSel = 2'b01; b_sew = 2'd0; b_addr = '0;
        repeat (3) @(negedge clk);

        chk("rst_valid", out_valid, 0);
        chk("rst_vec",   out_vec,   0);
        chk("rst_be",    out_be,    0);
        chk("rst_addr",  out_addr,  0);
        chk("rst_err",   out_err,   0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_err",   b_out_err,   0);

        rst = 1'b0;
        @(negedge clk);

        // XOR bytes 0x01..0x10, seed 0, single beat
        expect_a(128'h10, 16'h0001, 32'h100);
        beat_a(128'h100F0E0D0C0B0A090807060504030201, 128'h0, 16'hFFFF, 1, 1, 2'b11, 2'd0, 32'h100);

        // AND 32-bit elements, only elements 0 and 3 active, seed all ones
        expect_a(128'hFFFF0000, 16'h000F, 32'h200);
        beat_a(128'hFFFFFFFF_12345678_0000FFFF_FFFF0000, 128'hFFFFFFFF, 16'h0009, 1, 1, 2'b01, 2'd2, 32'h200);

        // OR 64-bit elements over two beats with a two-cycle bubble
        beat_a({64'h2, 64'h1}, 128'h10, 16'hFFFF, 1, 0, 2'b10, 2'd3, 32'h2F0);
        @(negedge clk);
        @(negedge clk);
        expect_a(128'h1F, 16'h00FF, 32'h300);
        beat_a({64'h8, 64'h4}, 128'h0, 16'hFFFF, 0, 1, 2'b10, 2'd3, 32'h300);

        // XOR bytes with only two active: 0x11 ^ 0x22 ^ seed 0x0F
        expect_a(128'h3C, 16'h0001, 32'h700);
        beat_a({{14{8'hFF}}, 8'h22, 8'h11}, 128'h0F, 16'h0003, 1, 1, 2'b11, 2'd0, 32'h700);

        // Back-to-back single-beat reductions
        expect_a(128'h0000, 16'h0003, 32'h400);
        beat_a({8{16'h00FF}}, 128'h0, 16'hFFFF, 1, 1, 2'b11, 2'd1, 32'h400);
        expect_a(128'h00FF, 16'h0003, 32'h410);
        beat_a({8{16'h00FF}}, 128'hFFFF, 16'hFFFF, 1, 1, 2'b01, 2'd1, 32'h410);

        // Illegal opSel beat is dropped; following end-only beat uses held acc 0x00FF
        qe_a.push_back(cyc + 1);
        beat_a(128'h0, 128'h0, 16'hFFFF, 1, 1, 2'b00, 2'd1, 32'h500);
        expect_a(128'h00FF, 16'h0003, 32'h510);
        beat_a({8{16'hFFFF}}, 128'h0, 16'hFFFF, 0, 1, 2'b01, 2'd1, 32'h510);

        repeat (12) @(negedge clk);

        // Reduction in flight discarded by reset
        beat_a({16{8'hAA}}, 128'h0, 16'hFFFF, 1, 1, 2'b10, 2'd0, 32'h600);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_addr",  out_addr,  0);
        chk("rst_mid_valid", out_valid, 0);
        expect_a(128'h00, 16'h0001, 32'h610);
        beat_a(128'h0, 128'h0, 16'hFFFF, 1, 1, 2'b10, 2'd0, 32'h610);

        // 64-bit instance: SEW=3 illegal, then a legal 16-bit OR reduction
        qe_b.push_back(cyc + 1);
        beat_b(64'h1, 64'h0, 8'hFF, 1, 1, 2'b10, 2'd3, 32'hB00);
        expect_b(128'h001F, 16'h0003, 32'hB10);
        beat_b(64'h0001_0002_0004_0008, 64'h10, 8'hFF, 1, 1, 2'b10, 2'd1, 32'hB10);

        repeat (15) @(negedge clk);

        chk("a_pending_results", q_a.size(),  0);
        chk("a_pending_errs",    qe_a.size(), 0);
        chk("b_pending_results", q_b.size(),  0);
        chk("b_pending_errs",    qe_b.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
